// File: rtl/count_bcd_display_if.sv
// Bundles the counter input and the BCD/display outputs of count_bcd_display.
interface count_bcd_display_if #(
  parameter int unsigned N = 6
);
  logic [N-1:0] count_in;
  logic [3:0]   tens;
  logic [3:0]   units;
  logic         bcd_valid;
  logic         busy;
  logic         wrap_tick;
  logic [6:0]   seg;
  logic [1:0]   an;

  // Upstream counter / checker side.
  modport master (
    output count_in,
    input  tens, units, bcd_valid, busy, wrap_tick, seg, an
  );

  // Display stage side.
  modport slave (
    input  count_in,
    output tens, units, bcd_valid, busy, wrap_tick, seg, an
  );
endinterface

// File: rtl/count_bcd_display.sv
// Display stage for the modulo-55 event counter: sequential shift-add-3 binary-to-BCD
// conversion, wrap detection and a two-digit multiplexed seven-segment driver.
module count_bcd_display #(
  parameter int unsigned N            = 6,
  parameter int unsigned WRAP         = 54,
  parameter int unsigned DIGIT_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  count_bcd_display_if.slave     io_bus
);

  localparam int unsigned CntW = $clog2(N + 1);
  localparam int unsigned RefW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

  localparam logic [N-1:0]    WrapVal = N'(WRAP);
  localparam logic [CntW-1:0] CntInit = CntW'(N);
  localparam logic [RefW-1:0] RefLast = RefW'(DIGIT_CYCLES - 1);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StConvert = 1'b1;

  logic [0:0]      r_state;
  logic [N-1:0]    r_last;
  logic [N-1:0]    r_prev;
  logic [N-1:0]    r_sh;
  logic [7:0]      r_acc;
  logic [CntW-1:0] r_cnt;
  logic [3:0]      r_tens;
  logic [3:0]      r_units;
  logic            r_bcd_valid;
  logic            r_wrap_tick;
  logic [RefW-1:0] r_ref;
  logic [1:0]      r_an;
  logic [6:0]      r_seg;

  logic [7:0]      w_acc_adj;
  logic [7:0]      w_acc_shift;
  logic [N-1:0]    w_sh_shift;
  logic            w_ref_term;
  logic [1:0]      w_an_next;
  logic [3:0]      w_digit;
  logic            w_blank;
  logic [6:0]      w_seg_dec;
  logic [6:0]      w_seg_next;

  // Add-3 correction on each BCD nibble, then one left shift of {acc, sh}.
  always_comb begin
    w_acc_adj[3:0] = (r_acc[3:0] >= 4'd5) ? r_acc[3:0] + 4'd3 : r_acc[3:0];
    w_acc_adj[7:4] = (r_acc[7:4] >= 4'd5) ? r_acc[7:4] + 4'd3 : r_acc[7:4];
    w_acc_shift    = {w_acc_adj[6:0], r_sh[N-1]};
    w_sh_shift     = r_sh << 1;
  end

  // Conversion FSM: sample a changed count in IDLE, shift N times in CONVERT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_last      <= '0;
      r_sh        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_tens      <= '0;
      r_units     <= '0;
      r_bcd_valid <= 1'b0;
    end else begin
      r_bcd_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (io_bus.count_in != r_last) begin
            r_sh    <= io_bus.count_in;
            r_last  <= io_bus.count_in;
            r_acc   <= '0;
            r_cnt   <= CntInit;
            r_state <= StConvert;
          end
        end
        StConvert: begin
          r_acc <= w_acc_shift;
          r_sh  <= w_sh_shift;
          r_cnt <= r_cnt - CntW'(1);
          // Last shift step: publish the finished digits.
          if (r_cnt == CntW'(1)) begin
            r_tens      <= w_acc_shift[7:4];
            r_units     <= w_acc_shift[3:0];
            r_bcd_valid <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Wrap detection runs every cycle regardless of conversion state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev      <= '0;
      r_wrap_tick <= 1'b0;
    end else begin
      r_prev      <= io_bus.count_in;
      r_wrap_tick <= (r_prev == WrapVal) && (io_bus.count_in == '0);
    end
  end

  // Digit select and segment decode for the value the mux will show next cycle.
  always_comb begin
    w_ref_term = (r_ref == RefLast);
    w_an_next  = w_ref_term ? {r_an[0], r_an[1]} : r_an;
    w_digit    = w_an_next[0] ? r_units : r_tens;
    w_blank    = w_an_next[1] && (r_tens == 4'd0);
    case (w_digit)
      4'd0:    w_seg_dec = 7'h3F;
      4'd1:    w_seg_dec = 7'h06;
      4'd2:    w_seg_dec = 7'h5B;
      4'd3:    w_seg_dec = 7'h4F;
      4'd4:    w_seg_dec = 7'h66;
      4'd5:    w_seg_dec = 7'h6D;
      4'd6:    w_seg_dec = 7'h7D;
      4'd7:    w_seg_dec = 7'h07;
      4'd8:    w_seg_dec = 7'h7F;
      4'd9:    w_seg_dec = 7'h6F;
      default: w_seg_dec = 7'h00;
    endcase
    w_seg_next = w_blank ? 7'h00 : w_seg_dec;
  end

  // Refresh counter, digit select and registered segment drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref <= '0;
      r_an  <= 2'b01;
      r_seg <= 7'h3F;
    end else begin
      r_ref <= w_ref_term ? '0 : r_ref + RefW'(1);
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign io_bus.tens      = r_tens;
  assign io_bus.units     = r_units;
  assign io_bus.bcd_valid = r_bcd_valid;
  assign io_bus.busy      = (r_state == StConvert);
  assign io_bus.wrap_tick = r_wrap_tick;
  assign io_bus.seg       = r_seg;
  assign io_bus.an        = r_an;

endmodule
